// File: rtl/fc_param_mem.sv
`default_nettype none
// ============================================================================
//  Module   : fc_param_mem
//  Purpose  : FC-layer parameter store. Two weight banks (class 0 / class 1)
//             and two bias registers, loaded over the fc_* cfg port, with
//             {w1,w0} weight pairs streamed out under valid/ready.
//  Options  : FC_CFG_LOCK_EN - drop cfg stores while a stream is running and
//             flag them on cfg_wr_err_o.
//  Revision : 1.0 - initial release
// ============================================================================
module fc_param_mem #(
   parameter int WEIGHT_BW = 8,
   parameter int BIAS_BW   = 32,
   parameter int DEPTH     = 208,
   parameter int ADDR_BW   = 8,
   parameter int BANK_BW   = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cfg_rd_en_i,
   input  logic                   cfg_wr_en_i,
   input  logic [BANK_BW-1:0]     cfg_bank_i,
   input  logic [ADDR_BW-1:0]     cfg_addr_i,
   input  logic [BIAS_BW-1:0]     cfg_wr_data_i,
   output logic [BIAS_BW-1:0]     cfg_rd_data_o,
   input  logic                   start_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   w_valid_o,
   input  logic                   w_ready_i,
   output logic [2*WEIGHT_BW-1:0] w_data_o,
   output logic                   w_last_o,
   output logic [BIAS_BW-1:0]     bias0_o,
   output logic [BIAS_BW-1:0]     bias1_o,
   output logic                   cfg_wr_err_o
);

   // The stream pointer needs one extra bit so it can reach DEPTH itself,
   // which is the "all reads issued" condition.
   localparam int                  PTR_BW    = ADDR_BW + 1;
   localparam int                  EXT_BW    = BIAS_BW - WEIGHT_BW;
   localparam logic [PTR_BW-1:0]   DEPTH_PTR = PTR_BW'(DEPTH);
   localparam logic [PTR_BW-1:0]   LAST_PTR  = PTR_BW'(DEPTH - 1);
   localparam logic [PTR_BW-1:0]   PTR_ONE   = PTR_BW'(1);
   localparam logic [BANK_BW-1:0]  BANK_W0   = BANK_BW'(0);
   localparam logic [BANK_BW-1:0]  BANK_W1   = BANK_BW'(1);
   localparam logic [BANK_BW-1:0]  BANK_B0   = BANK_BW'(2);
   localparam logic [BANK_BW-1:0]  BANK_B1   = BANK_BW'(3);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [PTR_BW-1:0]      rd_ptr_q, rd_ptr_d;
   logic                   w_valid_q, w_valid_d;
   logic                   w_last_q, w_last_d;
   logic [2*WEIGHT_BW-1:0] w_data_q, w_data_d;
   logic                   done_q, done_d;
   logic [BIAS_BW-1:0]     cfg_rd_data_q, cfg_rd_data_d;
   logic [BIAS_BW-1:0]     bias0_q, bias0_d;
   logic [BIAS_BW-1:0]     bias1_q, bias1_d;

   // Weight banks; deliberately not reset.
   logic [WEIGHT_BW-1:0]   w0_mem [0:DEPTH-1];
   logic [WEIGHT_BW-1:0]   w1_mem [0:DEPTH-1];

   logic                   cfg_access;
   logic                   addr_in_range;
   logic                   bank_is_w0;
   logic                   bank_is_w1;
   logic                   bank_is_b0;
   logic                   bank_is_b1;
   logic                   wr_blocked;
   logic                   mem_we0;
   logic                   mem_we1;
   logic                   start_accept;
   logic                   beat_taken;
   logic                   issue;
   logic [ADDR_BW-1:0]     port_addr;
   logic [WEIGHT_BW-1:0]   port_w0;
   logic [WEIGHT_BW-1:0]   port_w1;

   // Cfg port decode and the shared RAM read port address.
   always_comb begin
      cfg_access    = cfg_rd_en_i | cfg_wr_en_i;
      addr_in_range = ({1'b0, cfg_addr_i} < DEPTH_PTR);
      bank_is_w0    = (cfg_bank_i == BANK_W0);
      bank_is_w1    = (cfg_bank_i == BANK_W1);
      bank_is_b0    = (cfg_bank_i == BANK_B0);
      bank_is_b1    = (cfg_bank_i == BANK_B1);
      start_accept  = (state_q == ST_IDLE) & start_i;
      beat_taken    = w_valid_q & w_ready_i;
      // The cfg side owns the read port whenever it strobes; the stream only
      // issues in cycles without a cfg access, so there is never a conflict.
      port_addr     = cfg_access ? cfg_addr_i : rd_ptr_q[ADDR_BW-1:0];
      port_w0       = w0_mem[port_addr];
      port_w1       = w1_mem[port_addr];
   end

`ifdef FC_CFG_LOCK_EN
   logic wr_err_q, wr_err_d;

   // Stores are refused for the whole time a stream is in flight.
   always_comb begin
      wr_blocked = (state_q == ST_STREAM);
      wr_err_d   = wr_err_q;
      if (start_accept) begin
         wr_err_d = 1'b0;
      end
      if (cfg_wr_en_i && wr_blocked) begin
         wr_err_d = 1'b1;
      end
   end

   // Sticky dropped-store flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= wr_err_d;
      end
   end

   assign cfg_wr_err_o = wr_err_q;
`else
   assign wr_blocked   = 1'b0;
   assign cfg_wr_err_o = 1'b0;
`endif

   // Cfg loads and stores: registered load data, bias updates, RAM write enables.
   always_comb begin
      cfg_rd_data_d = cfg_rd_data_q;
      bias0_d       = bias0_q;
      bias1_d       = bias1_q;
      mem_we0       = 1'b0;
      mem_we1       = 1'b0;

      // Load reads old contents if a store hits the same location this cycle.
      if (cfg_rd_en_i) begin
         cfg_rd_data_d = '0;
         if (bank_is_w0 && addr_in_range) begin
            cfg_rd_data_d = {{EXT_BW{port_w0[WEIGHT_BW-1]}}, port_w0};
         end else if (bank_is_w1 && addr_in_range) begin
            cfg_rd_data_d = {{EXT_BW{port_w1[WEIGHT_BW-1]}}, port_w1};
         end else if (bank_is_b0) begin
            cfg_rd_data_d = bias0_q;
         end else if (bank_is_b1) begin
            cfg_rd_data_d = bias1_q;
         end
      end

      if (cfg_wr_en_i && !wr_blocked) begin
         mem_we0 = bank_is_w0 & addr_in_range;
         mem_we1 = bank_is_w1 & addr_in_range;
         if (bank_is_b0) begin
            bias0_d = cfg_wr_data_i;
         end
         if (bank_is_b1) begin
            bias1_d = cfg_wr_data_i;
         end
      end
   end

   // Stream FSM: read issue, output beat register and completion.
   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      w_valid_d = w_valid_q;
      w_last_d = w_last_q;
      w_data_d = w_data_q;
      done_d   = 1'b0;
      issue    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d  = ST_STREAM;
               rd_ptr_d = '0;
            end
         end
         ST_STREAM: begin
            // A read may only land in the output register once it is free or
            // being drained this cycle, so a stalled beat is never overwritten.
            issue = (rd_ptr_q < DEPTH_PTR) && (!w_valid_q || w_ready_i) && !cfg_access;
            if (issue) begin
               w_data_d  = {port_w1, port_w0};
               w_last_d  = (rd_ptr_q == LAST_PTR);
               w_valid_d = 1'b1;
               rd_ptr_d  = rd_ptr_q + PTR_ONE;
            end else if (beat_taken) begin
               w_valid_d = 1'b0;
               w_last_d  = 1'b0;
            end
            if (beat_taken && w_last_q) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         rd_ptr_q      <= '0;
         w_valid_q     <= 1'b0;
         w_last_q      <= 1'b0;
         w_data_q      <= '0;
         done_q        <= 1'b0;
         cfg_rd_data_q <= '0;
         bias0_q       <= '0;
         bias1_q       <= '0;
      end else begin
         state_q       <= state_d;
         rd_ptr_q      <= rd_ptr_d;
         w_valid_q     <= w_valid_d;
         w_last_q      <= w_last_d;
         w_data_q      <= w_data_d;
         done_q        <= done_d;
         cfg_rd_data_q <= cfg_rd_data_d;
         bias0_q       <= bias0_d;
         bias1_q       <= bias1_d;
      end
   end

   // Weight RAM write port.
   always_ff @(posedge clk_i) begin
      if (mem_we0) begin
         w0_mem[cfg_addr_i] <= cfg_wr_data_i[WEIGHT_BW-1:0];
      end
      if (mem_we1) begin
         w1_mem[cfg_addr_i] <= cfg_wr_data_i[WEIGHT_BW-1:0];
      end
   end

   assign busy_o        = (state_q == ST_STREAM);
   assign done_o        = done_q;
   assign w_valid_o     = w_valid_q;
   assign w_last_o      = w_last_q;
   assign w_data_o      = w_data_q;
   assign cfg_rd_data_o = cfg_rd_data_q;
   assign bias0_o       = bias0_q;
   assign bias1_o       = bias1_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_param_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fc_param_mem
//  Purpose  : Directed self-checking bench for fc_param_mem. Honours
//             FC_CFG_LOCK_EN for the store-while-busy scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fc_param_mem;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cfg_rd_en_i;
   logic        cfg_wr_en_i;
   logic [3:0]  cfg_bank_i;
   logic [7:0]  cfg_addr_i;
   logic [31:0] cfg_wr_data_i;
   logic [31:0] cfg_rd_data_o;
   logic        start_i;
   logic        busy_o;
   logic        done_o;
   logic        w_valid_o;
   logic        w_ready_i;
   logic [15:0] w_data_o;
   logic        w_last_o;
   logic [31:0] bias0_o;
   logic [31:0] bias1_o;
   logic        cfg_wr_err_o;

   int checks = 0;
   int errors = 0;

   // Reference contents of the parameter store.
   logic [7:0]  m0 [0:207];
   logic [7:0]  m1 [0:207];
   logic [31:0] mb0;
   logic [31:0] mb1;

   fc_param_mem dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .cfg_rd_en_i   (cfg_rd_en_i),
      .cfg_wr_en_i   (cfg_wr_en_i),
      .cfg_bank_i    (cfg_bank_i),
      .cfg_addr_i    (cfg_addr_i),
      .cfg_wr_data_i (cfg_wr_data_i),
      .cfg_rd_data_o (cfg_rd_data_o),
      .start_i       (start_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .w_valid_o     (w_valid_o),
      .w_ready_i     (w_ready_i),
      .w_data_o      (w_data_o),
      .w_last_o      (w_last_o),
      .bias0_o       (bias0_o),
      .bias1_o       (bias1_o),
      .cfg_wr_err_o  (cfg_wr_err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] sext8(input logic [7:0] v);
      return {{24{v[7]}}, v};
   endfunction

   // One store cycle; called at a falling edge, returns at the next one.
   task automatic cfg_write(input logic [3:0] b, input logic [7:0] a, input logic [31:0] d);
      cfg_wr_en_i   = 1'b1;
      cfg_bank_i    = b;
      cfg_addr_i    = a;
      cfg_wr_data_i = d;
      if (b == 4'd0 && a < 8'd208) m0[a] = d[7:0];
      if (b == 4'd1 && a < 8'd208) m1[a] = d[7:0];
      if (b == 4'd2) mb0 = d;
      if (b == 4'd3) mb1 = d;
      @(negedge clk_i);
      cfg_wr_en_i = 1'b0;
   endtask

   // One load cycle, result checked one cycle later and again one cycle after
   // that (value must hold with no load issued).
   task automatic cfg_read(input string name, input logic [3:0] b, input logic [7:0] a,
                           input logic [31:0] exp);
      cfg_rd_en_i = 1'b1;
      cfg_bank_i  = b;
      cfg_addr_i  = a;
      @(negedge clk_i);
      cfg_rd_en_i = 1'b0;
      checks++;
      if (cfg_rd_data_o !== exp) begin
         errors++;
         $display("FAIL %s: rd_data got 0x%08h expected 0x%08h", name, cfg_rd_data_o, exp);
      end
      @(negedge clk_i);
      checks++;
      if (cfg_rd_data_o !== exp) begin
         errors++;
         $display("FAIL %s_hold: rd_data got 0x%08h expected 0x%08h", name, cfg_rd_data_o, exp);
      end
   endtask

   // Runs one stream from a start pulse, checking every beat against the model.
   // c counts falling edges after the one that raised start_i.
   task automatic stream_run(input bit rnd_ready, input bit do_loads, input int rst_beat,
                             input int wr_cycle, input logic [3:0] wb, input logic [7:0] wa,
                             input logic [31:0] wd,
                             output int beats, output int first_cyc, output int done_cyc);
      bit          pend_rd;
      logic [31:0] pend_exp;
      bit          prev_stall;
      logic [15:0] prev_data;
      logic        prev_last;
      logic [7:0]  la;
      beats      = 0;
      first_cyc  = -1;
      done_cyc   = -1;
      pend_rd    = 1'b0;
      pend_exp   = '0;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      start_i    = 1'b1;
      w_ready_i  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 1; c < 3000; c++) begin
         @(negedge clk_i);
         start_i     = 1'b0;
         cfg_rd_en_i = 1'b0;
         cfg_wr_en_i = 1'b0;
         if (pend_rd) begin
            checks++;
            if (cfg_rd_data_o !== pend_exp) begin
               errors++;
               $display("FAIL stream_load c=%0d: got 0x%08h expected 0x%08h", c, cfg_rd_data_o, pend_exp);
            end
            pend_rd = 1'b0;
         end
         if (done_o) begin
            done_cyc = c;
            checks++;
            if (busy_o !== 1'b0 || w_valid_o !== 1'b0) begin
               errors++;
               $display("FAIL done_state: busy=%b valid=%b expected 0 0", busy_o, w_valid_o);
            end
            break;
         end
         if (rst_beat >= 0 && w_valid_o && beats == rst_beat) begin
            rst_i = 1'b1;
            #1;
            checks++;
            if (w_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
               errors++;
               $display("FAIL mid_reset: valid=%b busy=%b done=%b expected 0 0 0",
                        w_valid_o, busy_o, done_o);
            end
            @(negedge clk_i);
            rst_i     = 1'b0;
            w_ready_i = 1'b0;
            mb0       = '0;
            mb1       = '0;
            break;
         end
         if (rnd_ready) w_ready_i = 1'($urandom_range(0, 1));
         if (prev_stall) begin
            checks++;
            if (w_valid_o !== 1'b1 || w_data_o !== prev_data || w_last_o !== prev_last) begin
               errors++;
               $display("FAIL stall_hold c=%0d: valid=%b data=0x%04h last=%b expected 1 0x%04h %b",
                        c, w_valid_o, w_data_o, w_last_o, prev_data, prev_last);
            end
         end
         if (w_valid_o) begin
            if (first_cyc < 0) first_cyc = c;
            if (w_ready_i) begin
               checks++;
               if (beats > 207) begin
                  errors++;
                  $display("FAIL extra_beat: beat %0d data 0x%04h beyond 208", beats, w_data_o);
               end else if (w_data_o !== {m1[beats], m0[beats]} ||
                            w_last_o !== (beats == 207)) begin
                  errors++;
                  $display("FAIL beat %0d: data=0x%04h last=%b expected 0x%04h %b", beats,
                           w_data_o, w_last_o, {m1[beats], m0[beats]}, (beats == 207));
               end
               beats++;
            end
         end
         prev_stall = w_valid_o & ~w_ready_i;
         prev_data  = w_data_o;
         prev_last  = w_last_o;
         if (do_loads && (c % 10) == 0) begin
            la          = 8'(c % 208);
            cfg_rd_en_i = 1'b1;
            cfg_bank_i  = 4'd0;
            cfg_addr_i  = la;
            pend_exp    = sext8(m0[la]);
            pend_rd     = 1'b1;
         end
         if (c == wr_cycle) begin
            cfg_wr_en_i   = 1'b1;
            cfg_bank_i    = wb;
            cfg_addr_i    = wa;
            cfg_wr_data_i = wd;
`ifndef FC_CFG_LOCK_EN
            if (wb == 4'd0) m0[wa] = wd[7:0];
            if (wb == 4'd1) m1[wa] = wd[7:0];
`endif
         end
      end
      start_i     = 1'b0;
      cfg_rd_en_i = 1'b0;
      cfg_wr_en_i = 1'b0;
   endtask

   task automatic test_reset;
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || w_valid_o !== 1'b0 || w_last_o !== 1'b0 ||
          w_data_o !== 16'h0 || cfg_rd_data_o !== 32'h0 || bias0_o !== 32'h0 ||
          bias1_o !== 32'h0 || cfg_wr_err_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b valid=%b last=%b data=0x%04h rd=0x%08h b0=0x%08h b1=0x%08h err=%b expected all 0",
                  busy_o, done_o, w_valid_o, w_last_o, w_data_o, cfg_rd_data_o,
                  bias0_o, bias1_o, cfg_wr_err_o);
      end
   endtask

   task automatic test_weight_cfg;
      cfg_write(4'd0, 8'h05, 32'h0000_00FF);
      cfg_write(4'd1, 8'h05, 32'h0000_007F);
      cfg_read("load_w0_neg", 4'd0, 8'h05, 32'hFFFF_FFFF);
      cfg_read("load_w1_pos", 4'd1, 8'h05, 32'h0000_007F);
   endtask

   task automatic test_bias_cfg;
      cfg_write(4'd2, 8'h00, 32'h1234_5678);
      checks++;
      if (bias0_o !== 32'h1234_5678) begin
         errors++;
         $display("FAIL bias0: got 0x%08h expected 0x12345678", bias0_o);
      end
      cfg_write(4'd3, 8'h77, 32'hFFFF_FF00);
      checks++;
      if (bias1_o !== 32'hFFFF_FF00 || bias0_o !== 32'h1234_5678) begin
         errors++;
         $display("FAIL bias1: got 0x%08h/0x%08h expected 0xFFFFFF00/0x12345678", bias1_o, bias0_o);
      end
      cfg_read("load_bias1", 4'd3, 8'h00, 32'hFFFF_FF00);
   endtask

   task automatic test_out_of_range;
      cfg_write(4'd0, 8'hD0, 32'h0000_0055);
      cfg_write(4'd1, 8'hFF, 32'h0000_0066);
      cfg_write(4'd5, 8'h05, 32'h0000_0099);
      cfg_write(4'd4, 8'h00, 32'hDEAD_BEEF);
      checks++;
      if (bias0_o !== 32'h1234_5678 || bias1_o !== 32'hFFFF_FF00) begin
         errors++;
         $display("FAIL oor_bias: got 0x%08h/0x%08h expected 0x12345678/0xFFFFFF00", bias0_o, bias1_o);
      end
      cfg_read("oor_addr_load", 4'd0, 8'hD0, 32'h0);
      cfg_read("w0_after_oor", 4'd0, 8'h05, 32'hFFFF_FFFF);
      cfg_read("oor_bank_load", 4'd5, 8'h05, 32'h0);
      cfg_read("w1_after_oor", 4'd1, 8'h05, 32'h0000_007F);
   endtask

   task automatic test_stream_full;
      int beats, first_cyc, done_cyc;
      for (int i = 0; i < 208; i++) begin
         cfg_write(4'd0, 8'(i), 32'(i));
         cfg_write(4'd1, 8'(i), 32'(8'(256 - i)));
      end
      stream_run(1'b0, 1'b0, -1, -1, 4'd0, 8'd0, 32'd0, beats, first_cyc, done_cyc);
      checks++;
      if (beats != 208 || first_cyc != 2 || done_cyc != 210) begin
         errors++;
         $display("FAIL stream_timing: beats=%0d first=%0d done=%0d expected 208 2 210",
                  beats, first_cyc, done_cyc);
      end
   endtask

   task automatic test_random_ready;
      int beats, first_cyc, done_cyc;
      stream_run(1'b1, 1'b1, -1, -1, 4'd0, 8'd0, 32'd0, beats, first_cyc, done_cyc);
      checks++;
      if (beats != 208 || done_cyc < 0) begin
         errors++;
         $display("FAIL random_ready: beats=%0d done_cyc=%0d expected 208 and done seen",
                  beats, done_cyc);
      end
      w_ready_i = 1'b0;
   endtask

   task automatic test_cfg_during_stream;
      int beats, first_cyc, done_cyc;
      stream_run(1'b0, 1'b0, -1, 25, 4'd1, 8'd150, 32'h0000_0033, beats, first_cyc, done_cyc);
      checks++;
      if (beats != 208 || done_cyc != 211) begin
         errors++;
         $display("FAIL wr_stall: beats=%0d done=%0d expected 208 211", beats, done_cyc);
      end
`ifdef FC_CFG_LOCK_EN
      checks++;
      if (cfg_wr_err_o !== 1'b1) begin
         errors++;
         $display("FAIL wr_err_set: got %b expected 1", cfg_wr_err_o);
      end
      cfg_read("locked_drop", 4'd1, 8'd150, sext8(m1[150]));
      checks++;
      if (cfg_wr_err_o !== 1'b1) begin
         errors++;
         $display("FAIL wr_err_sticky: got %b expected 1", cfg_wr_err_o);
      end
`else
      cfg_read("stream_wr_seen", 4'd1, 8'd150, 32'h0000_0033);
`endif
      stream_run(1'b0, 1'b0, -1, -1, 4'd0, 8'd0, 32'd0, beats, first_cyc, done_cyc);
      checks++;
      if (cfg_wr_err_o !== 1'b0 || beats != 208) begin
         errors++;
         $display("FAIL wr_err_clear: err=%b beats=%0d expected 0 208", cfg_wr_err_o, beats);
      end
   endtask

   task automatic test_reset_mid;
      int beats, first_cyc, done_cyc;
      stream_run(1'b0, 1'b0, 100, -1, 4'd0, 8'd0, 32'd0, beats, first_cyc, done_cyc);
      checks++;
      if (beats != 100 || done_cyc != -1 || bias0_o !== 32'h0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_state: beats=%0d done=%0d bias0=0x%08h busy=%b expected 100 -1 0 0",
                  beats, done_cyc, bias0_o, busy_o);
      end
      w_ready_i = 1'b1;
      stream_run(1'b0, 1'b0, -1, -1, 4'd0, 8'd0, 32'd0, beats, first_cyc, done_cyc);
      checks++;
      if (beats != 208 || first_cyc != 2 || done_cyc != 210) begin
         errors++;
         $display("FAIL restart: beats=%0d first=%0d done=%0d expected 208 2 210",
                  beats, first_cyc, done_cyc);
      end
   endtask

   initial begin
      rst_i         = 1'b1;
      cfg_rd_en_i   = 1'b0;
      cfg_wr_en_i   = 1'b0;
      cfg_bank_i    = '0;
      cfg_addr_i    = '0;
      cfg_wr_data_i = '0;
      start_i       = 1'b0;
      w_ready_i     = 1'b0;
      mb0           = '0;
      mb1           = '0;
      for (int i = 0; i < 208; i++) begin
         m0[i] = '0;
         m1[i] = '0;
      end
      repeat (3) @(negedge clk_i);
      test_reset;
      rst_i = 1'b0;
      @(negedge clk_i);
      test_reset;
      test_weight_cfg;
      test_bias_cfg;
      test_out_of_range;
      test_stream_full;
      test_random_ready;
      test_cfg_during_stream;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
